rom_stream_reader: RTL and testbench

- Command-driven sequencer that sits directly upstream of a ROMMEM instance.
- Accepts a (base, length) burst command and issues sequential read_addr/read_en to the ROM.
- Captures read_data and presents it as a valid/ready stream with a last-beat marker.
- Hides ROM read latency (async or sync-read) and absorbs downstream backpressure with a 2-entry output buffer, so no ROM word is ever dropped.

---
 rtl/rom_stream_reader.sv | 117 +++++++++++
 tb/tb_rom_stream_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Burst reader for a ROMMEM instance: turns (base, length) commands into sequential
// ROM reads and replays the words as a valid/ready stream through a 2-entry buffer.
module rom_stream_reader #(
  parameter int DEPTH        = 16,
  parameter int ADDRBITS     = 4,
  parameter int WIDTH        = 8,
  parameter int IS_SYNC_READ = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDRBITS-1:0] cmd_base,
  input  logic [ADDRBITS:0]   cmd_len,
  output logic [ADDRBITS-1:0] rom_addr,
  output logic                rom_en,
  input  logic [WIDTH-1:0]    rom_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic                busy
);

  // Handshakes: a transfer happens on a rising clock edge where valid && ready are both
  // high; valid never waits on ready, and a held-off offer is simply repeated.

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDRBITS:0] MAX_LEN = (ADDRBITS + 1)'(DEPTH);
  localparam logic [ADDRBITS:0] ONE     = (ADDRBITS + 1)'(1);

  state_t              state;
  logic [ADDRBITS-1:0] addr_q;
  logic [ADDRBITS-1:0] last_addr;
  logic [ADDRBITS:0]   rem_issue;
  logic [ADDRBITS:0]   rem_out;
  logic                inflight;
  logic [WIDTH-1:0]    mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occupancy;
  logic [ADDRBITS:0]   len_eff;

  always_comb begin
    out_valid = (count != 2'd0);
    pop       = out_valid && out_ready;
    // Slots still claimed after this cycle's pop; a read may go out only if one is free.
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = (state == RUN) && (rem_issue != '0) && (occupancy < 3'd2);
    push      = (IS_SYNC_READ != 0) ? inflight : issue;
    rom_en    = issue;
    rom_addr  = issue ? addr_q : last_addr;
    out_data  = mem[rd_ptr];
    out_last  = out_valid && (rem_out == ONE);
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    len_eff   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      last_addr <= '0;
      rem_issue <= '0;
      rem_out   <= '0;
      inflight  <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rom_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        rem_out <= rem_out - ONE;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (IS_SYNC_READ != 0) inflight <= issue;
      if (issue) begin
        last_addr <= addr_q;
        addr_q    <= addr_q + 1'b1;
        rem_issue <= rem_issue - ONE;
      end
      case (state)
        IDLE: begin
          if (cmd_valid && (cmd_len != '0)) begin
            addr_q    <= cmd_base;
            rem_issue <= len_eff;
            rem_out   <= len_eff;
            state     <= RUN;
          end
        end
        RUN: begin
          if (issue && (rem_issue == ONE)) state <= DRAIN;
        end
        DRAIN: begin
          // Final beat leaves on this pop, or everything already left.
          if ((pop && (rem_out == ONE)) ||
              ((rem_out == '0) && (count == 2'd0) && !inflight)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: one async-read and one sync-read instance, each fed by
// a ROM model holding ROM[i]=i*3, checked against an expected-beat scoreboard.
module tb_rom_stream_reader;

  localparam int AB = 4;
  localparam int W  = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic [1:0]    cmd_valid, cmd_ready, rom_en, out_valid, out_ready, out_last, busy;
  logic [AB-1:0] cmd_base [2];
  logic [AB:0]   cmd_len  [2];
  logic [AB-1:0] rom_addr [2];
  logic [W-1:0]  out_data [2];
  logic [W-1:0]  rom_data_a, rom_data_s;
  logic [W-1:0]  rom_mem [16];

  rom_stream_reader #(.DEPTH(16), .ADDRBITS(AB), .WIDTH(W), .IS_SYNC_READ(0)) u_async (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_base(cmd_base[0]), .cmd_len(cmd_len[0]),
    .rom_addr(rom_addr[0]), .rom_en(rom_en[0]), .rom_data(rom_data_a),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .busy(busy[0])
  );

  rom_stream_reader #(.DEPTH(16), .ADDRBITS(AB), .WIDTH(W), .IS_SYNC_READ(1)) u_sync (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_base(cmd_base[1]), .cmd_len(cmd_len[1]),
    .rom_addr(rom_addr[1]), .rom_en(rom_en[1]), .rom_data(rom_data_s),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .busy(busy[1])
  );

  // ROM models: combinational read for the async instance, registered for the sync one.
  always_comb rom_data_a = rom_mem[rom_addr[0]];
  always @(posedge clock) if (rom_en[1]) rom_data_s <= rom_mem[rom_addr[1]];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int act = 0;
  int beats, issues, first_beat, last_beat, first_issue, last_issue;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;

  logic [W-1:0]  exp_q  [$];
  logic          last_q [$];
  logic [AB-1:0] addr_q [$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor on the active instance, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("stall_valid", out_valid[act], 1);
        check_val("stall_data", out_data[act], prev_data);
      end
      if (rom_en[act]) begin
        check_val("issue_expected", 32'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) check_val("rom_addr", rom_addr[act], addr_q.pop_front());
        if (issues == 0) first_issue = cyc;
        last_issue = cyc;
        issues++;
      end
      if (out_valid[act] && out_ready[act]) begin
        check_val("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check_val("out_data", out_data[act], exp_q.pop_front());
          check_val("out_last", out_last[act], last_q.pop_front());
        end
        if (beats == 0) first_beat = cyc;
        last_beat = cyc;
        beats++;
      end
      if (rom_en[act]) check_val("outstanding_le2", 32'((issues - beats) <= 2), 1);
      prev_stall = out_valid[act] && !out_ready[act];
      prev_data  = out_data[act];
    end
  end

  task automatic clear_stats();
    beats = 0; issues = 0; first_beat = 0; last_beat = 0; first_issue = 0; last_issue = 0;
  endtask

  task automatic send_cmd(input int k, input int base, input int len);
    int n;
    for (int i = 0; i < len; i++) begin
      addr_q.push_back(AB'(base + i));
      exp_q.push_back(rom_mem[(base + i) % 16]);
      last_q.push_back(i == len - 1);
    end
    cmd_base[k]  = AB'(base);
    cmd_len[k]   = (AB + 1)'(len);
    cmd_valid[k] = 1'b1;
    n = 0;
    @(negedge clock);
    while (!cmd_ready[k] && n < 200) begin
      n++;
      @(negedge clock);
    end
    check_val("cmd_accept", cmd_ready[k], 1);
    @(posedge clock);
    #1 cmd_valid[k] = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0 repeating; 2: random ready.
  task automatic run_until_idle(input int k, input int mode);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 600) begin
      @(posedge clock);
      #1;
      case (mode)
        0:       out_ready[k] = 1'b1;
        1:       out_ready[k] = (n % 3 == 0);
        default: out_ready[k] = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clock);
      done = !busy[k] && (exp_q.size() == 0);
      n++;
    end
    check_val("burst_done", done, 1);
    @(posedge clock);
    #1 out_ready[k] = 1'b1;
  endtask

  task automatic burst(input int k, input int base, input int len, input int mode, input int exp_lat);
    int lat;
    lat = 0;
    clear_stats();
    send_cmd(k, base, len);
    check_val("busy_after_accept", busy[k], 1);
    check_val("cmd_ready_while_busy", cmd_ready[k], 0);
    @(negedge clock);
    while (!out_valid[k] && lat < 20) begin
      lat++;
      @(negedge clock);
    end
    check_val("first_valid_latency", lat, exp_lat);
    run_until_idle(k, mode);
    check_val("beat_count", beats, len);
    check_val("issue_count", issues, len);
    if (mode == 0) begin
      check_val("beats_back_to_back", last_beat - first_beat, len - 1);
      check_val("issues_back_to_back", last_issue - first_issue, len - 1);
    end
    check_val("cmd_ready_idle", cmd_ready[k], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rom_mem[i] = W'(i * 3);
    reset = 1'b0;
    cmd_valid = 2'b00;
    out_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      cmd_base[k] = '0;
      cmd_len[k]  = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val("rst_cmd_ready", cmd_ready[k], 1);
      check_val("rst_rom_en", rom_en[k], 0);
      check_val("rst_rom_addr", rom_addr[k], 0);
      check_val("rst_out_valid", out_valid[k], 0);
      check_val("rst_out_data", out_data[k], 0);
      check_val("rst_out_last", out_last[k], 0);
      check_val("rst_busy", busy[k], 0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Async read: plain burst, wrap-around, backpressure, random backpressure.
    act = 0;
    burst(0, 2, 4, 0, 1);
    burst(0, 14, 4, 0, 1);
    burst(0, 9, 8, 1, 1);
    burst(0, 6, 16, 2, 1);

    // Sync read: full-depth burst, backpressure, random.
    act = 1;
    burst(1, 0, 16, 0, 2);
    burst(1, 3, 8, 1, 2);
    burst(1, 11, 7, 2, 2);

    // Zero-length command followed by a single-beat command.
    act = 0;
    clear_stats();
    send_cmd(0, 4, 0);
    check_val("len0_busy", busy[0], 0);
    repeat (5) @(negedge clock);
    check_val("len0_issues", issues, 0);
    check_val("len0_beats", beats, 0);
    check_val("len0_out_valid", out_valid[0], 0);
    check_val("len0_cmd_ready", cmd_ready[0], 1);
    @(posedge clock);
    #1;
    burst(0, 7, 1, 0, 1);

    // Reset pulled low mid-burst after three beats.
    clear_stats();
    send_cmd(0, 0, 16);
    n = 0;
    while (beats < 3 && n < 50) begin
      n++;
      @(negedge clock);
    end
    check_val("mid_reset_beats_seen", 32'(beats >= 3), 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_val("mid_reset_out_valid", out_valid[0], 0);
    check_val("mid_reset_busy", busy[0], 0);
    check_val("mid_reset_cmd_ready", cmd_ready[0], 1);
    check_val("mid_reset_rom_en", rom_en[0], 0);
    exp_q.delete();
    last_q.delete();
    addr_q.delete();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    burst(0, 5, 2, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
